// File: rtl/e203_ifu_flush_rsp_pkg.sv
// Shared definitions for the IFU flush responder: state encoding and PC width.
package e203_ifu_flush_rsp_pkg;

    localparam int unsigned E203_PC_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ISSUE = 2'd2
    } flush_state_e;

endpackage

// File: rtl/e203_ifu_flush_rsp_ostd_cnt.sv
// Up/down saturating counter for outstanding fetch requests, with a sticky
// error flag raised on overflow past MAX or underflow below zero.
module e203_ifu_ostd_cnt #(
    parameter int unsigned MAX = 2,
    parameter int unsigned W   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt_nxt,
    output logic         err
);

    localparam logic [W-1:0] MAX_CNT = W'(MAX);

    logic [W-1:0] cnt;
    logic         ovf;
    logic         unf;

    always_comb begin
        cnt_nxt = cnt;
        ovf     = 1'b0;
        unf     = 1'b0;
        if (inc && !dec) begin
            if (cnt == MAX_CNT) begin
                ovf = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end else if (dec && !inc) begin
            if (cnt == '0) begin
                unf = 1'b1;
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            err <= err | ovf | unf;
        end
    end

endmodule

// File: rtl/e203_ifu_flush_rsp.sv
// IFU responder for commit-stage flushes: computes the redirect PC, drops stale
// fetch responses, and issues a single redirect to the PC generator.
module e203_ifu_flush_rsp
    import e203_ifu_flush_rsp_pkg::*;
#(
    parameter int unsigned PC_SIZE  = E203_PC_SIZE,
    parameter int unsigned OSTD_MAX = 2,
    parameter int unsigned OSTD_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pipe_flush_req,
    input  logic [PC_SIZE-1:0] pipe_flush_add_op1,
    input  logic [PC_SIZE-1:0] pipe_flush_add_op2,
    output logic               pipe_flush_ack,
    input  logic               ifu_req_hsked,
    input  logic               ifu_rsp_hsked,
    output logic               ifu_rsp_drop,
    output logic               fetch_block,
    output logic               redir_valid,
    input  logic               redir_ready,
    output logic [PC_SIZE-1:0] redir_pc,
    output logic               ostd_err
);

    flush_state_e        state;
    flush_state_e        state_nxt;
    logic                flush_hsk;
    logic [OSTD_W-1:0]   ostd_cnt_nxt;
    logic [OSTD_W-1:0]   drop_cnt;
    logic [OSTD_W-1:0]   drop_cnt_nxt;
    logic [PC_SIZE-1:0]  tgt_pc;
    logic [PC_SIZE-1:0]  tgt_pc_nxt;

    e203_ifu_ostd_cnt #(
        .MAX (OSTD_MAX),
        .W   (OSTD_W)
    ) u_ostd_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (ifu_req_hsked),
        .dec     (ifu_rsp_hsked),
        .cnt_nxt (ostd_cnt_nxt),
        .err     (ostd_err)
    );

    assign pipe_flush_ack = 1'b1;
    assign flush_hsk      = pipe_flush_req & pipe_flush_ack;
    assign ifu_rsp_drop   = (drop_cnt != '0);
    assign fetch_block    = (state != IDLE) | pipe_flush_req;

    always_comb begin
        tgt_pc_nxt   = tgt_pc;
        drop_cnt_nxt = drop_cnt;
        if (flush_hsk) begin
            tgt_pc_nxt   = pipe_flush_add_op1 + pipe_flush_add_op2;
            drop_cnt_nxt = ostd_cnt_nxt;
        end else if (ifu_rsp_drop && ifu_rsp_hsked) begin
            drop_cnt_nxt = drop_cnt - 1'b1;
        end
    end

    // A new flush always wins over the current state, including a redirect
    // handshake in the same cycle (that handshake still consumes the old PC).
    always_comb begin
        state_nxt = state;
        if (flush_hsk) begin
            state_nxt = (drop_cnt_nxt != '0) ? DRAIN : ISSUE;
        end else begin
            case (state)
                DRAIN:   if (drop_cnt_nxt == '0) state_nxt = ISSUE;
                ISSUE:   if (redir_ready)        state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            drop_cnt    <= '0;
            tgt_pc      <= '0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
        end else begin
            state       <= state_nxt;
            drop_cnt    <= drop_cnt_nxt;
            tgt_pc      <= tgt_pc_nxt;
            redir_valid <= (state_nxt == ISSUE);
            if (state_nxt == ISSUE) begin
                redir_pc <= tgt_pc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_e203_ifu_flush_rsp.sv
// Directed bench for the IFU flush responder with hand-computed expectations.
module tb_e203_ifu_flush_rsp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_flush_req;
    logic [31:0] pipe_flush_add_op1;
    logic [31:0] pipe_flush_add_op2;
    logic        pipe_flush_ack;
    logic        ifu_req_hsked;
    logic        ifu_rsp_hsked;
    logic        ifu_rsp_drop;
    logic        fetch_block;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        ostd_err;

    int vectors     = 0;
    int miscompares = 0;

    e203_ifu_flush_rsp #(
        .PC_SIZE  (32),
        .OSTD_MAX (2),
        .OSTD_W   (2)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pipe_flush_req     (pipe_flush_req),
        .pipe_flush_add_op1 (pipe_flush_add_op1),
        .pipe_flush_add_op2 (pipe_flush_add_op2),
        .pipe_flush_ack     (pipe_flush_ack),
        .ifu_req_hsked      (ifu_req_hsked),
        .ifu_rsp_hsked      (ifu_rsp_hsked),
        .ifu_rsp_drop       (ifu_rsp_drop),
        .fetch_block        (fetch_block),
        .redir_valid        (redir_valid),
        .redir_ready        (redir_ready),
        .redir_pc           (redir_pc),
        .ostd_err           (ostd_err)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n              = 1'b0;
        pipe_flush_req     = 1'b0;
        pipe_flush_add_op1 = '0;
        pipe_flush_add_op2 = '0;
        ifu_req_hsked      = 1'b0;
        ifu_rsp_hsked      = 1'b0;
        redir_ready        = 1'b0;
        #3;
        vectors++;
        if ({pipe_flush_ack, ifu_rsp_drop, fetch_block, redir_valid, ostd_err} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_flags got=%b want=10000",
                     {pipe_flush_ack, ifu_rsp_drop, fetch_block, redir_valid, ostd_err});
        end
        vectors++;
        if (redir_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_pc got=%h want=00000000", redir_pc);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_idle_flush();
        pipe_flush_req     = 1'b1;
        pipe_flush_add_op1 = 32'h8000_0100;
        pipe_flush_add_op2 = 32'h0000_0004;
        #1;
        vectors++;
        if ({pipe_flush_ack, fetch_block, redir_valid} !== 3'b110) begin
            miscompares++;
            $display("FAIL idle_flush_cycle got=%b want=110", {pipe_flush_ack, fetch_block, redir_valid});
        end
        step();
        pipe_flush_req = 1'b0;
        #1;
        vectors++;
        if (redir_valid !== 1'b1 || redir_pc !== 32'h8000_0104 || fetch_block !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_flush_redir got=%b/%h/%b want=1/80000104/1", redir_valid, redir_pc, fetch_block);
        end
        redir_ready = 1'b1;
        step();
        redir_ready = 1'b0;
        #1;
        vectors++;
        if (redir_valid !== 1'b0 || fetch_block !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_flush_done got=%b/%b want=0/0", redir_valid, fetch_block);
        end
    endtask

    task automatic test_drain();
        ifu_req_hsked = 1'b1;
        step();
        step();
        ifu_req_hsked      = 1'b0;
        pipe_flush_req     = 1'b1;
        pipe_flush_add_op1 = 32'h0000_1000;
        pipe_flush_add_op2 = 32'hFFFF_F000;
        step();
        pipe_flush_req = 1'b0;
        ifu_rsp_hsked  = 1'b1;
        #1;
        vectors++;
        if (ifu_rsp_drop !== 1'b1 || redir_valid !== 1'b0 || fetch_block !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_rsp1 got=%b/%b/%b want=1/0/1", ifu_rsp_drop, redir_valid, fetch_block);
        end
        step();
        #1;
        vectors++;
        if (ifu_rsp_drop !== 1'b1 || redir_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_rsp2 got=%b/%b want=1/0", ifu_rsp_drop, redir_valid);
        end
        step();
        ifu_rsp_hsked = 1'b0;
        #1;
        vectors++;
        if (redir_valid !== 1'b1 || redir_pc !== 32'h0 || ifu_rsp_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_redir got=%b/%h/%b want=1/00000000/0", redir_valid, redir_pc, ifu_rsp_drop);
        end
        redir_ready = 1'b1;
        step();
        redir_ready = 1'b0;
        #1;
        vectors++;
        if (redir_valid !== 1'b0 || fetch_block !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_done got=%b/%b want=0/0", redir_valid, fetch_block);
        end
    endtask

    task automatic test_same_cycle_req();
        ifu_req_hsked      = 1'b1;
        pipe_flush_req     = 1'b1;
        pipe_flush_add_op1 = 32'h0000_0040;
        pipe_flush_add_op2 = 32'h0000_0010;
        step();
        ifu_req_hsked  = 1'b0;
        pipe_flush_req = 1'b0;
        #1;
        vectors++;
        if (ifu_rsp_drop !== 1'b1 || redir_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL same_cycle_drop got=%b/%b want=1/0", ifu_rsp_drop, redir_valid);
        end
        ifu_rsp_hsked = 1'b1;
        step();
        ifu_rsp_hsked = 1'b0;
        #1;
        vectors++;
        if (redir_valid !== 1'b1 || redir_pc !== 32'h50 || ifu_rsp_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL same_cycle_redir got=%b/%h/%b want=1/00000050/0", redir_valid, redir_pc, ifu_rsp_drop);
        end
        redir_ready = 1'b1;
        step();
        redir_ready = 1'b0;
    endtask

    task automatic test_override_drain();
        ifu_req_hsked = 1'b1;
        step();
        step();
        ifu_req_hsked      = 1'b0;
        pipe_flush_req     = 1'b1;
        pipe_flush_add_op1 = 32'h0000_0100;
        pipe_flush_add_op2 = 32'h0000_0100;
        step();
        pipe_flush_req = 1'b0;
        ifu_rsp_hsked  = 1'b1;
        step();
        ifu_rsp_hsked      = 1'b0;
        pipe_flush_req     = 1'b1;
        pipe_flush_add_op1 = 32'h0000_0300;
        pipe_flush_add_op2 = 32'h0000_0000;
        step();
        pipe_flush_req = 1'b0;
        #1;
        vectors++;
        if (redir_valid !== 1'b0 || ifu_rsp_drop !== 1'b1) begin
            miscompares++;
            $display("FAIL override_still_drain got=%b/%b want=0/1", redir_valid, ifu_rsp_drop);
        end
        ifu_rsp_hsked = 1'b1;
        step();
        ifu_rsp_hsked = 1'b0;
        vectors++;
        if (redir_valid !== 1'b1 || redir_pc !== 32'h300) begin
            miscompares++;
            $display("FAIL override_redir got=%b/%h want=1/00000300", redir_valid, redir_pc);
        end
        redir_ready = 1'b1;
        step();
        redir_ready = 1'b0;
        #1;
        vectors++;
        if (redir_valid !== 1'b0 || fetch_block !== 1'b0) begin
            miscompares++;
            $display("FAIL override_single got=%b/%b want=0/0", redir_valid, fetch_block);
        end
    endtask

    task automatic test_back_to_back();
        pipe_flush_req     = 1'b1;
        pipe_flush_add_op1 = 32'h0000_0200;
        pipe_flush_add_op2 = 32'h0000_0050;
        step();
        pipe_flush_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (redir_valid !== 1'b1 || redir_pc !== 32'h250) begin
                miscompares++;
                $display("FAIL backpressure_hold[%0d] got=%b/%h want=1/00000250", i, redir_valid, redir_pc);
            end
            step();
        end
        redir_ready        = 1'b1;
        pipe_flush_req     = 1'b1;
        pipe_flush_add_op1 = 32'h0000_03F0;
        pipe_flush_add_op2 = 32'h0000_0010;
        #1;
        vectors++;
        if (redir_pc !== 32'h250) begin
            miscompares++;
            $display("FAIL override_old_consumed got=%h want=00000250", redir_pc);
        end
        step();
        pipe_flush_req = 1'b0;
        vectors++;
        if (redir_valid !== 1'b1 || redir_pc !== 32'h400) begin
            miscompares++;
            $display("FAIL override_new_redir got=%b/%h want=1/00000400", redir_valid, redir_pc);
        end
        step();
        redir_ready = 1'b0;
        vectors++;
        if (redir_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL override_new_done got=%b want=0", redir_valid);
        end
    endtask

    task automatic test_err_reset();
        ifu_req_hsked = 1'b1;
        step();
        step();
        vectors++;
        if (ostd_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_at_max got=%b want=0", ostd_err);
        end
        step();
        ifu_req_hsked = 1'b0;
        vectors++;
        if (ostd_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_overflow got=%b want=1", ostd_err);
        end
        pipe_flush_req     = 1'b1;
        pipe_flush_add_op1 = 32'h0000_0600;
        pipe_flush_add_op2 = 32'h0000_0000;
        step();
        pipe_flush_req = 1'b0;
        #1;
        vectors++;
        if (ifu_rsp_drop !== 1'b1 || redir_valid !== 1'b0 || ostd_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_drain got=%b/%b/%b want=1/0/1", ifu_rsp_drop, redir_valid, ostd_err);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({pipe_flush_ack, ifu_rsp_drop, fetch_block, redir_valid, ostd_err} !== 5'b10000
            || redir_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset got=%b/%h want=10000/00000000",
                     {pipe_flush_ack, ifu_rsp_drop, fetch_block, redir_valid, ostd_err}, redir_pc);
        end
        step();
        rst_n = 1'b1;
        ifu_rsp_hsked = 1'b1;
        step();
        ifu_rsp_hsked = 1'b0;
        vectors++;
        if (ostd_err !== 1'b1 || ifu_rsp_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL err_underflow got=%b/%b want=1/0", ostd_err, ifu_rsp_drop);
        end
    endtask

    initial begin
        test_reset();
        test_idle_flush();
        test_drain();
        test_same_cycle_req();
        test_override_drain();
        test_back_to_back();
        test_err_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/e203_ifu_flush_rsp.md
Name: e203_ifu_flush_rsp

Overview:
- IFU-side responder for the commit-stage pipeline flush interface.
- Accepts flush request plus the two adder operands from the EXU branch/flush resolve logic, and acknowledges it.
- Computes the redirect PC and drains or discards in-flight fetch responses.
- Issues one redirect request to the IFU PC generator, and blocks sequential fetch until the redirect is taken.

Parameters:
- PC_SIZE, 32, width of PC and flush operands (matches E203_PC_SIZE)
- OSTD_MAX, 2, maximum outstanding fetch requests on the ICB/ifetch bus
- OSTD_W, 2, counter width; must satisfy 2^OSTD_W > OSTD_MAX

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- pipe_flush_req  in  1  flush request from EXU commit
- pipe_flush_add_op1  in  PC_SIZE  target adder operand 1
- pipe_flush_add_op2  in  PC_SIZE  target adder operand 2
- pipe_flush_ack  out  1  flush accepted this cycle
- ifu_req_hsked  in  1  fetch request handshake on bus this cycle
- ifu_rsp_hsked  in  1  fetch response handshake on bus this cycle
- ifu_rsp_drop  out  1  current response is stale; IFU must discard it
- fetch_block  out  1  suppress new sequential fetch requests
- redir_valid  out  1  redirect request to PC generator
- redir_ready  in  1  PC generator accepts redirect
- redir_pc  out  PC_SIZE  redirect target
- ostd_err  out  1  sticky: counter overflow/underflow detected

Behaviour:
- Reset values:
  - state=IDLE; ostd_cnt=0; drop_cnt=0; tgt_pc=0; ostd_err=0.
  - All outputs 0, except pipe_flush_ack, which is 1 (see below).
- pipe_flush_ack = 1 in every state. The responder never stalls commit; a new flush always overrides an older pending one.
- Flush accept (flush_hsk = req & ack):
  - tgt_pc <= op1 + op2, truncated to PC_SIZE (wrap-around, no carry-out).
  - Latency is one cycle to redir_valid when nothing is in flight.
- Outstanding counter:
  - ostd_cnt +1 on ifu_req_hsked, -1 on ifu_rsp_hsked, unchanged when both occur in the same cycle.
  - Increment at OSTD_MAX, or decrement at 0, sets ostd_err and leaves the count saturated.
- Drop counter on flush_hsk:
  - drop_cnt <= ostd_cnt_nxt, i.e. in-flight count including a request handshaked the same cycle, minus a response handshaked the same cycle.
  - While drop_cnt != 0: ifu_rsp_drop = 1, and each ifu_rsp_hsked decrements drop_cnt.
  - A request handshaked after flush acceptance is not counted. fetch_block prevents such requests anyway.
- fetch_block = (state != IDLE) | pipe_flush_req. It is combinational, so the flush cycle itself is blocked.
- State machine, states IDLE, DRAIN, ISSUE:
  - IDLE: on flush_hsk, go to DRAIN if drop_cnt_nxt != 0, else go to ISSUE.
  - DRAIN: redir_valid = 0. When drop_cnt reaches 0 (last drop response handshake), go to ISSUE. A new flush_hsk reloads tgt_pc and drop_cnt and stays in DRAIN, or goes to ISSUE if drop_cnt_nxt == 0.
  - ISSUE: redir_valid = 1 and redir_pc = tgt_pc, both held stable until redir_ready. On handshake, go to IDLE.
- New flush_hsk while in ISSUE:
  - tgt_pc is updated and the state re-evaluates via the IDLE rule, landing in ISSUE or DRAIN.
  - If this coincides with a redirect handshake, the redirect is still consumed with the old PC, and the new target is issued afterwards.
- Reset mid-operation: asynchronous clear to the reset values. In-flight bus responses after reset are the bus owner's concern and are not dropped by this block.
- All registers use async-reset DFFs. Flopped outputs: redir_valid, redir_pc, ostd_err. Combinational outputs: pipe_flush_ack, fetch_block, ifu_rsp_drop.

Decomposition:
- Shared package/defines: state encoding constants (IDLE=2'd0, DRAIN=2'd1, ISSUE=2'd2); PC_SIZE sourced from the core PC-size define.
- One sub-module, e203_ifu_ostd_cnt: an up/down saturating counter with an error flag, instantiated for ostd_cnt.
- drop_cnt logic stays inline because of its load-on-flush behaviour.

Test Plan:
- Idle flush, nothing in flight: op1=0x8000_0100, op2=0x4, ostd=0. Expect ack the same cycle, redir_valid next cycle with redir_pc=0x8000_0104; redir_ready=1 returns the block to IDLE and fetch_block drops.
- Drain: two requests in flight, then flush op1=0x1000, op2=0xFFFF_F000. Expect ifu_rsp_drop on both responses and redir_valid=0 until the second response. Then redir_pc=0x0000_0000 (wrap-around).
- Same-cycle request and flush: ifu_req_hsked and flush_hsk in the same cycle with ostd=0. Expect drop_cnt=1, the one response dropped, then ISSUE.
- Override in DRAIN: flush A (target 0x200), a second flush B (target 0x300) before the drain completes. Expect a single redirect with redir_pc=0x300.
- Backpressure and override: redir_ready=0 for 5 cycles, so redir_valid and redir_pc are held stable. A flush with target 0x400 coinciding with redir_ready=1 yields a consumed old redirect, then a second redirect with redir_pc=0x400.
- Error plus async reset: force 3 request handshakes with OSTD_MAX=2, expect ostd_err=1. Assert rst_n low mid-DRAIN and expect all reset values immediately.
